// File: rtl/slurm16_pkg.sv
// rtl/slurm16_pkg.sv - shared opcode encoding and datapath constants for the SLURM16 ALU
package slurm16_pkg;

  localparam int BITS    = 16;
  localparam int OP_BITS = 5;

  // Opcode encoding seen on the aluOp port; 29..31 all behave as NOP.
  typedef enum logic [OP_BITS-1:0] {
    ALU_MOV   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_ADC   = 5'd2,
    ALU_SUB   = 5'd3,
    ALU_SBB   = 5'd4,
    ALU_AND   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_XOR   = 5'd7,
    ALU_MUL   = 5'd8,
    ALU_MULU  = 5'd9,
    ALU_RRN   = 5'd10,
    ALU_RLN   = 5'd11,
    ALU_CMP   = 5'd12,
    ALU_TEST  = 5'd13,
    ALU_UMULU = 5'd14,
    ALU_BSWAP = 5'd15,
    ALU_ASR   = 5'd16,
    ALU_LSR   = 5'd17,
    ALU_LSL   = 5'd18,
    ALU_ROLC  = 5'd19,
    ALU_RORC  = 5'd20,
    ALU_ROL   = 5'd21,
    ALU_ROR   = 5'd22,
    ALU_CC    = 5'd23,
    ALU_SC    = 5'd24,
    ALU_CZ    = 5'd25,
    ALU_SZ    = 5'd26,
    ALU_CS    = 5'd27,
    ALU_SS    = 5'd28,
    ALU_NOP   = 5'd29
  } alu_op_e;

  // Architectural flag register.
  typedef struct packed {
    logic c;
    logic z;
    logic s;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/slurm16_alu_mul.sv
// rtl/slurm16_alu_mul.sv - 16x16 multiplier giving low word plus signed and unsigned high words
module slurm16_alu_mul #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] lo,
  output logic [BITS-1:0] hi_s,
  output logic [BITS-1:0] hi_u
);

  logic signed [2*BITS-1:0] prod_s;
  logic        [BITS-1:0]   corr_a;
  logic        [BITS-1:0]   corr_b;

  // A single signed multiplier serves all three results. The low word is
  // identical for signed and unsigned operands. The unsigned high word
  // differs from the signed one by adding each operand whenever the other
  // operand's sign bit is set (mod 2^BITS), so no second multiplier is needed.
  always_comb begin
    prod_s = $signed(a) * $signed(b);
    corr_a = a[BITS-1] ? b : '0;
    corr_b = b[BITS-1] ? a : '0;
    lo     = prod_s[BITS-1:0];
    hi_s   = prod_s[2*BITS-1:BITS];
    hi_u   = prod_s[2*BITS-1:BITS] + corr_a + corr_b;
  end

endmodule

// File: rtl/slurm16_alu_core.sv
// rtl/slurm16_alu_core.sv - registered 16-bit ALU with architectural C/Z/S/V flag register
module slurm16_alu_core #(
  parameter int BITS    = 16,
  parameter int OP_BITS = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BITS-1:0]    A,
  input  logic [BITS-1:0]    B,
  input  logic [OP_BITS-1:0] aluOp,
  output logic [BITS-1:0]    aluOut,
  output logic               C,
  output logic               Z,
  output logic               S,
  output logic               V,
  input  logic               C_in,
  input  logic               Z_in,
  input  logic               S_in,
  input  logic               V_in,
  input  logic               load_flags
);

  import slurm16_pkg::*;

  localparam int MSB = BITS - 1;

  alu_op_e    op;
  alu_flags_t flags_q;
  alu_flags_t flags_d;
  logic [BITS-1:0] result;
  logic [BITS-1:0] flag_src;   // value Z/S are derived from (differs from result for CMP/TEST)
  logic            upd_zs;
  logic [BITS:0]   sum;
  logic [BITS:0]   diff;
  logic [BITS-1:0] mul_lo;
  logic [BITS-1:0] mul_hi_s;
  logic [BITS-1:0] mul_hi_u;

  assign op = alu_op_e'(aluOp);

  slurm16_alu_mul #(.BITS(BITS)) u_mul (
    .a    (A),
    .b    (B),
    .lo   (mul_lo),
    .hi_s (mul_hi_s),
    .hi_u (mul_hi_u)
  );

  // Compute next result and next flag register from operands, opcode and current flags.
  always_comb begin
    result   = A;
    flag_src = '0;
    upd_zs   = 1'b0;
    flags_d  = flags_q;
    sum      = '0;
    diff     = '0;

    case (op)
      ALU_MOV: result = B;

      ALU_ADD, ALU_ADC: begin
        sum       = {1'b0, A} + {1'b0, B}
                  + {{BITS{1'b0}}, (op == ALU_ADC) ? flags_q.c : 1'b0};
        result    = sum[MSB:0];
        flag_src  = sum[MSB:0];
        upd_zs    = 1'b1;
        flags_d.c = sum[BITS];
        flags_d.v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end

      // The 17th bit of the extended difference is the borrow out.
      ALU_SUB, ALU_SBB, ALU_CMP: begin
        diff      = {1'b0, A} - {1'b0, B}
                  - {{BITS{1'b0}}, (op == ALU_SBB) ? flags_q.c : 1'b0};
        result    = (op == ALU_CMP) ? A : diff[MSB:0];
        flag_src  = diff[MSB:0];
        upd_zs    = 1'b1;
        flags_d.c = diff[BITS];
        flags_d.v = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end

      ALU_AND: begin result = A & B; flag_src = A & B; upd_zs = 1'b1; end
      ALU_OR:  begin result = A | B; flag_src = A | B; upd_zs = 1'b1; end
      ALU_XOR: begin result = A ^ B; flag_src = A ^ B; upd_zs = 1'b1; end
      ALU_TEST: begin result = A;    flag_src = A & B; upd_zs = 1'b1; end

      ALU_MUL:   begin result = mul_lo;   flag_src = mul_lo;   upd_zs = 1'b1; end
      ALU_MULU:  begin result = mul_hi_s; flag_src = mul_hi_s; upd_zs = 1'b1; end
      ALU_UMULU: begin result = mul_hi_u; flag_src = mul_hi_u; upd_zs = 1'b1; end

      ALU_RRN: begin
        result   = {A[3:0], A[MSB:4]};
        flag_src = {A[3:0], A[MSB:4]};
        upd_zs   = 1'b1;
      end
      ALU_RLN: begin
        result   = {A[MSB-4:0], A[MSB:MSB-3]};
        flag_src = {A[MSB-4:0], A[MSB:MSB-3]};
        upd_zs   = 1'b1;
      end
      ALU_BSWAP: begin
        result   = {A[7:0], A[MSB:8]};
        flag_src = {A[7:0], A[MSB:8]};
        upd_zs   = 1'b1;
      end

      // Single-bit shifts and rotates: C receives the bit that falls off.
      ALU_ASR: begin
        result    = {A[MSB], A[MSB:1]};
        flag_src  = {A[MSB], A[MSB:1]};
        upd_zs    = 1'b1;
        flags_d.c = A[0];
      end
      ALU_LSR: begin
        result    = {1'b0, A[MSB:1]};
        flag_src  = {1'b0, A[MSB:1]};
        upd_zs    = 1'b1;
        flags_d.c = A[0];
      end
      ALU_LSL: begin
        result    = {A[MSB-1:0], 1'b0};
        flag_src  = {A[MSB-1:0], 1'b0};
        upd_zs    = 1'b1;
        flags_d.c = A[MSB];
      end
      ALU_ROLC: begin
        result    = {A[MSB-1:0], flags_q.c};
        flag_src  = {A[MSB-1:0], flags_q.c};
        upd_zs    = 1'b1;
        flags_d.c = A[MSB];
      end
      ALU_RORC: begin
        result    = {flags_q.c, A[MSB:1]};
        flag_src  = {flags_q.c, A[MSB:1]};
        upd_zs    = 1'b1;
        flags_d.c = A[0];
      end
      ALU_ROL: begin
        result    = {A[MSB-1:0], A[MSB]};
        flag_src  = {A[MSB-1:0], A[MSB]};
        upd_zs    = 1'b1;
        flags_d.c = A[MSB];
      end
      ALU_ROR: begin
        result    = {A[0], A[MSB:1]};
        flag_src  = {A[0], A[MSB:1]};
        upd_zs    = 1'b1;
        flags_d.c = A[0];
      end

      ALU_CC: flags_d.c = 1'b0;
      ALU_SC: flags_d.c = 1'b1;
      ALU_CZ: flags_d.z = 1'b0;
      ALU_SZ: flags_d.z = 1'b1;
      ALU_CS: flags_d.s = 1'b0;
      ALU_SS: flags_d.s = 1'b1;

      default: result = A;
    endcase

    if (upd_zs) begin
      flags_d.z = (flag_src == '0);
      flags_d.s = flag_src[MSB];
    end

    // Restoring flags from the pipeline overrides whatever the op produced.
    if (load_flags) begin
      flags_d = '{c: C_in, z: Z_in, s: S_in, v: V_in};
    end
  end

  // Register result and flags; reset discards any in-flight result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      aluOut  <= '0;
      flags_q <= '0;
    end else begin
      aluOut  <= result;
      flags_q <= flags_d;
    end
  end

  assign C = flags_q.c;
  assign Z = flags_q.z;
  assign S = flags_q.s;
  assign V = flags_q.v;

endmodule

// File: tb/tb_slurm16_alu_core.sv
// tb/tb_slurm16_alu_core.sv - scoreboard bench for slurm16_alu_core against a behavioural model
module tb_slurm16_alu_core;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [4:0]  aluOp = '0;
  logic [15:0] aluOut;
  logic        C, Z, S, V;
  logic        C_in = 1'b0, Z_in = 1'b0, S_in = 1'b0, V_in = 1'b0;
  logic        load_flags = 1'b0;

  typedef struct {
    int          op;
    logic [15:0] out;
    bit          c, z, s, v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference flag state as seen by the next issued operation.
  bit mc = 0, mz = 0, ms = 0, mv = 0;

  slurm16_alu_core dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .aluOp(aluOp), .aluOut(aluOut),
    .C(C), .Z(Z), .S(S), .V(V),
    .C_in(C_in), .Z_in(Z_in), .S_in(S_in), .V_in(V_in), .load_flags(load_flags)
  );

  always #5 CLK = ~CLK;

  // Behavioural model working on plain integers.
  task automatic model(input int op, input int a, input int b, input bit lf,
                       input bit ci, input bit zi, input bit si, input bit vi,
                       output exp_t e);
    int     r, fr, cin;
    longint p;
    bit     nc, nz, ns, nv, upd;
    nc = mc; nz = mz; ns = ms; nv = mv; upd = 0; fr = 0; r = a;
    case (op)
      0: r = b;
      1, 2: begin
        cin = (op == 2) ? int'(mc) : 0;
        r   = (a + b + cin) & 32'hFFFF;
        nc  = (a + b + cin) > 65535;
        nv  = (((a >> 15) & 1) == ((b >> 15) & 1)) && (((r >> 15) & 1) != ((a >> 15) & 1));
        fr = r; upd = 1;
      end
      3, 4, 12: begin
        cin = (op == 4) ? int'(mc) : 0;
        fr  = (a - b - cin) & 32'hFFFF;
        nc  = a < (b + cin);
        nv  = (((a >> 15) & 1) != ((b >> 15) & 1)) && (((fr >> 15) & 1) != ((a >> 15) & 1));
        r   = (op == 12) ? a : fr;
        upd = 1;
      end
      5:  begin r = a & b; fr = r; upd = 1; end
      6:  begin r = a | b; fr = r; upd = 1; end
      7:  begin r = a ^ b; fr = r; upd = 1; end
      13: begin r = a; fr = a & b; upd = 1; end
      8, 9: begin
        p = longint'($signed(16'(a))) * longint'($signed(16'(b)));
        r = (op == 8) ? int'(p & 64'hFFFF) : int'((p >>> 16) & 64'hFFFF);
        fr = r; upd = 1;
      end
      14: begin
        p = longint'(a) * longint'(b);
        r = int'((p >> 16) & 64'hFFFF); fr = r; upd = 1;
      end
      10: begin r = ((a >> 4) | (a << 12)) & 32'hFFFF; fr = r; upd = 1; end
      11: begin r = ((a << 4) | (a >> 12)) & 32'hFFFF; fr = r; upd = 1; end
      15: begin r = ((a & 255) << 8) | (a >> 8); fr = r; upd = 1; end
      16: begin r = (a >> 1) | (a & 32768); nc = a[0]; fr = r; upd = 1; end
      17: begin r = a >> 1; nc = a[0]; fr = r; upd = 1; end
      18: begin r = (a << 1) & 32'hFFFF; nc = a[15]; fr = r; upd = 1; end
      19: begin r = ((a << 1) & 32'hFFFF) | int'(mc); nc = a[15]; fr = r; upd = 1; end
      20: begin r = (a >> 1) | (int'(mc) << 15); nc = a[0]; fr = r; upd = 1; end
      21: begin r = ((a << 1) & 32'hFFFF) | (a >> 15); nc = a[15]; fr = r; upd = 1; end
      22: begin r = (a >> 1) | ((a & 1) << 15); nc = a[0]; fr = r; upd = 1; end
      23: nc = 0;
      24: nc = 1;
      25: nz = 0;
      26: nz = 1;
      27: ns = 0;
      28: ns = 1;
      default: r = a;
    endcase
    if (upd) begin
      nz = (fr == 0);
      ns = fr[15];
    end
    if (lf) begin
      nc = ci; nz = zi; ns = si; nv = vi;
    end
    mc = nc; mz = nz; ms = ns; mv = nv;
    e.op = op; e.out = r[15:0]; e.c = nc; e.z = nz; e.s = ns; e.v = nv;
  endtask

  task automatic issue(input int op, input logic [15:0] a, input logic [15:0] b,
                       input bit lf = 0, input bit ci = 0, input bit zi = 0,
                       input bit si = 0, input bit vi = 0);
    exp_t e;
    @(negedge CLK);
    aluOp = op[4:0]; A = a; B = b;
    load_flags = lf; C_in = ci; Z_in = zi; S_in = si; V_in = vi;
    model(op, int'(a), int'(b), lf, ci, zi, si, vi, e);
    exp_q.push_back(e);
  endtask

  task automatic issue_random();
    bit lf;
    lf = ($urandom_range(0, 7) == 0);
    issue(int'($urandom_range(0, 31)), 16'($urandom), 16'($urandom),
          lf, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (aluOut !== 16'h0 || {C, Z, S, V} !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s: got out=%h CZSV=%b%b%b%b, expected out=0000 CZSV=0000",
               name, aluOut, C, Z, S, V);
    end
  endtask

  // Async reset in the middle of a cycle, with an operation in flight.
  task automatic reset_midstream();
    issue(1, 16'h1234, 16'h4321);
    #2 RST = 1'b1;
    #1 check_zero("async_reset_immediate");
    exp_q.delete();
    mc = 0; mz = 0; ms = 0; mv = 0;
    aluOp = 5'd29; load_flags = 1'b0;
    @(negedge CLK);
    check_zero("reset_held_over_edge");
    RST = 1'b0;
  endtask

  // Monitor: every edge after an issued operation delivers one checked result.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (aluOut !== e.out || {C, Z, S, V} !== {e.c, e.z, e.s, e.v}) begin
          n_bad++;
          $display("FAIL op%0d: got out=%h CZSV=%b%b%b%b, expected out=%h CZSV=%b%b%b%b",
                   e.op, aluOut, C, Z, S, V, e.out, e.c, e.z, e.s, e.v);
        end
      end
    end
  end

  initial begin
    #1 check_zero("reset_state");
    @(negedge CLK);
    RST = 1'b0;

    issue(1, 16'h0003, 16'h0007);
    issue(1, 16'hFFFF, 16'h0001);
    issue(3, 16'h8000, 16'h0001);
    issue(12, 16'h0002, 16'h0005);
    issue(24, 16'h0000, 16'h0000);
    issue(2, 16'h0001, 16'h0001);
    issue(20, 16'h0001, 16'h0000);
    issue(8, 16'hFFFF, 16'h0002);
    issue(9, 16'hFFFF, 16'h0002);
    issue(14, 16'hFFFF, 16'h0002);
    issue(1, 16'h0000, 16'h0000, 1, 1, 0, 1, 1);
    issue(0, 16'hBEEF, 16'h5A5A);
    issue(4, 16'h0000, 16'h0000);
    issue(16, 16'h8001, 16'h0000);
    issue(19, 16'h8000, 16'h0000);
    issue(15, 16'h12AB, 16'h0000);
    issue(30, 16'hCAFE, 16'h0000);

    for (int i = 0; i < 400; i++) issue_random();
    reset_midstream();
    for (int i = 0; i < 200; i++) issue_random();

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
